// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, registered-read memory between the fetch and data ports.
// Define MEM_ARB_SUBWORD_EN to add byte/halfword accesses, with sub-word stores done as read-modify-write.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WAIT     = 3'd2,
    WRITE    = 3'd3,
`ifdef MEM_ARB_SUBWORD_EN
    RMW_RD   = 3'd4,
    RMW_WAIT = 3'd5,
`endif
    DONE     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  state_t        state, state_nxt;
  owner_t        owner;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   addr_q, mwdata_q, if_rdata_q, d_rdata_q;
  logic          grant_data, grant_fetch;

  // Data has priority unless fetch has already been passed over STARVE_LIMIT times in a row.
  assign grant_data  = d_req && !(if_req && starve_cnt == LIMIT);
  assign grant_fetch = if_req && !grant_data;

`ifdef MEM_ARB_SUBWORD_EN
  logic [15:0] wdata_q;
  logic [1:0]  size_q, off_q;
  logic [4:0]  lane_sh;
  logic [31:0] lane_mask, rd_value, merged;

  // Big-endian lanes: byte offset 0 is the top byte, halfword offset 0 the top half.
  assign lane_sh   = size_q[0] ? (off_q[1] ? 5'd0 : 5'd16) : {2'd3 - off_q, 3'b000};
  assign lane_mask = size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
  assign rd_value  = size_q[1] ? mem_rdata : ((mem_rdata >> lane_sh) & lane_mask);
  assign merged    = (mem_rdata & ~(lane_mask << lane_sh))
                   | (({16'h0000, wdata_q} & lane_mask) << lane_sh);
  assign mem_read  = (state == READ) || (state == RMW_RD);
`else
  logic unused_size;
  assign unused_size = ^d_size;
  assign mem_read    = (state == READ);
`endif

  assign mem_write = (state == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = mwdata_q;
  assign if_ack    = (state == DONE) && (owner == OWN_FETCH);
  assign d_ack     = (state == DONE) && (owner == OWN_DATA);
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_data) begin
          if (!d_we)
            state_nxt = READ;
`ifdef MEM_ARB_SUBWORD_EN
          else if (!d_size[1])
            state_nxt = RMW_RD;
`endif
          else
            state_nxt = WRITE;
        end else if (grant_fetch) begin
          state_nxt = READ;
        end
      end
      READ:     state_nxt = WAIT;
      WAIT:     state_nxt = DONE;
      WRITE:    state_nxt = DONE;
`ifdef MEM_ARB_SUBWORD_EN
      RMW_RD:   state_nxt = RMW_WAIT;
      RMW_WAIT: state_nxt = WRITE;
`endif
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // mem_wdata only moves when a write is about to happen, so it holds its last value otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      addr_q     <= '0;
      mwdata_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
`ifdef MEM_ARB_SUBWORD_EN
      wdata_q    <= '0;
      size_q     <= '0;
      off_q      <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (!if_req || grant_fetch)
            starve_cnt <= '0;
          else if (grant_data && starve_cnt != LIMIT)
            starve_cnt <= starve_cnt + 1'b1;
          if (grant_data) begin
            owner <= OWN_DATA;
`ifdef MEM_ARB_SUBWORD_EN
            wdata_q <= d_wdata[15:0];
            size_q  <= d_size;
            off_q   <= d_addr[1:0];
            addr_q  <= d_size[1] ? d_addr : {d_addr[31:2], 2'b00};
            if (d_we && d_size[1])
              mwdata_q <= d_wdata;
`else
            addr_q <= d_addr;
            if (d_we)
              mwdata_q <= d_wdata;
`endif
          end else if (grant_fetch) begin
            owner  <= OWN_FETCH;
            addr_q <= if_addr;
          end
        end
        WAIT: begin
          if (owner == OWN_FETCH)
            if_rdata_q <= mem_rdata;
          else
`ifdef MEM_ARB_SUBWORD_EN
            d_rdata_q <= rd_value;
`else
            d_rdata_q <= mem_rdata;
`endif
        end
`ifdef MEM_ARB_SUBWORD_EN
        RMW_WAIT: mwdata_q <= merged;
`endif
        DONE:    owner <= OWN_NONE;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer placed in front of the single-ported byte-addressable data memory of the MIPS core. It shares the memory between the instruction-fetch port and the data (load/store) port, and sequences each access through the memory's one-cycle registered read. When enabled, it also builds byte and halfword stores as read-modify-write (RMW) sequences. The data port has priority, with a starvation bound that protects instruction fetch.

## Interface
- STARVE_LIMIT, 4: maximum consecutive data-port grants while `if_req` is pending.

- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; a level held until `if_ack`
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetched word; valid while `if_ack`=1
- if_ack  out  1  one-cycle completion pulse
- d_req  in  1  data request; a level held until `d_ack`
- d_we  in  1  1=store, 0=load
- d_size  in  2  00 byte, 01 half, 10/11 word
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-justified for byte/half
- d_rdata  out  32  load data; valid while `d_ack`=1
- d_ack  out  1  one-cycle completion pulse
- mem_read, mem_write  out  1  memory strobes; never both high
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write word
- mem_rdata  in  32  memory read word; valid the cycle after `mem_read` is sampled

## Operation
- FSM states: IDLE, READ, WAIT, WRITE, RMW_RD, RMW_WAIT, DONE.
- IDLE arbitration:
  - If `d_req`=1, grant data, unless `if_req`=1 and `starve_cnt`==STARVE_LIMIT; in that case grant fetch.
  - Otherwise, if `if_req`=1, grant fetch.
  - The grant latches the owner, address, size, we and wdata.
- `starve_cnt`:
  - Increments on each data grant while `if_req`=1, saturating at STARVE_LIMIT.
  - Clears on a fetch grant, or in any IDLE cycle with `if_req`=0.
- Transitions:
  - Fetch or load: IDLE→READ→WAIT→DONE.
  - Word store: IDLE→WRITE→DONE.
  - Sub-word store: IDLE→RMW_RD→RMW_WAIT→WRITE→DONE.
  - DONE→IDLE, always.
- READ and RMW_RD assert `mem_read`. WRITE asserts `mem_write`. `mem_*` outputs decode from state and latched fields. In all other states the strobes are 0 and `mem_addr`/`mem_wdata` hold their last value.
- In WAIT and RMW_WAIT, `mem_rdata` is registered; for RMW it is merged with the store data.
- DONE asserts only the owner's ack. `rdata` holds the registered word and is unchanged until the next completion on that port.
- Byte lanes are big-endian: offset 0 is bits 31:24, offset 3 is bits 7:0. Halfword offset 0 is bits 31:16 and offset 2 is bits 15:0.
- Requesters hold request inputs stable from `req` high until `ack`. They drop `req` in the cycle after `ack`, so no duplicate grant occurs.

## Timing
- Reset values (rst_n=0 at a posedge): state=IDLE, `if_ack`=`d_ack`=0, `if_rdata`=`d_rdata`=0, `starve_cnt`=0, owner=none. `mem_read`=`mem_write`=0 and `mem_addr`=`mem_wdata`=0 from the next cycle.
- Latency, with a request first sampled in IDLE at cycle 0:
  - Read or fetch: ack in cycle 3.
  - Word store: ack in cycle 2.
  - RMW store: ack in cycle 4.
- Throughput: back-to-back reads by one port take 5 cycles each, counting the `req` drop cycle.
- Simultaneous `if_req` and `d_req` in IDLE: data wins unless the starvation limit is reached. The loser waits in IDLE for the next arbitration.
- Reset during operation: the access is aborted and no ack is issued.
  - A WRITE state present at the reset edge commits its write.
  - An RMW aborted before WRITE leaves memory unchanged.
- A request arriving while busy is not lost. It is sampled at the next IDLE.

## Configuration
- `MEM_ARB_SUBWORD_EN` defined:
  - Sub-word stores use RMW on the word-aligned address (`d_addr`&~3), merging only the addressed lane(s).
  - Sub-word loads read the aligned word and return the lane zero-extended in `d_rdata`.
  - Halfword address bit 0 is ignored.
  - Word accesses use `d_addr` unmodified.
- Not defined: `d_size` is ignored. Every access is a full word at `d_addr` unmodified. The RMW_RD and RMW_WAIT states are not compiled in.

## Test plan
- Word store then load: store 0xDEADBEEF at 400. `d_ack` in cycle 2 and memory bytes 400..403 become DE AD BE EF. A load of 400 gives `d_rdata`=0xDEADBEEF with `d_ack` in cycle 3.
- Contention: `if_req` and `d_req` both held from cycle 0. Data acks first; fetch is granted at the next IDLE. Each ack is exactly one cycle and goes only to its owner.
- Starvation: hold `if_req` and keep issuing back-to-back data loads. Exactly 4 data grants complete, then fetch is granted; `starve_cnt` clears to 0.
- RMW (macro defined): word 0x11223344 at 400, then byte store 0xAA at 402. Memory becomes 0x1122AA44 and `d_ack` comes in cycle 4. A half load at 400 returns 0x00001122.
- Reset mid-RMW: assert rst_n=0 in RMW_WAIT. No `d_ack` appears, memory at 400 is unchanged, and all outputs take their reset values.
- Macro off: a byte store of 0x000000AA at 402 writes the full word 00 00 00 AA to bytes 402..405.
